ca_vga_renderer: RTL and testbench
==================================

// Module: ca_vga_renderer
// PURPOSE
// Elementary (1-D, 3-neighbour) cellular-automaton renderer for the 640x480 VGA path. Consumes
// hvsync_generator timing (pix_x/pix_y/video_active/syncs) and drives TinyVGA RGB222 plus delayed syncs.
// Rule, boundary mode, seed mode and per-frame scrolling are runtime-selectable. One clk = one pixel.
// PARAMETERS
// H_ACTIVE      640        visible pixels per line
// V_ACTIVE      480        visible lines per frame
// GRID_W        100        cells per row (>=3)
// LOG_CELL      2          log2 of cell edge in pixels (CELL=1<<LOG_CELL)
// RULE_DEFAULT  8'd30      Wolfram rule loaded at reset
// FG_COLOR      6'b101100  RGB222 {R,G,B} for live cells
// BG_COLOR      6'b000000  RGB222 for dead cells inside grid
// LFSR_INIT     16'hACE1   random-seed LFSR reset value (nonzero)
// PORTS
// clk           in   1   pixel clock
// rst_n         in   1   reset, synchronous, active-low
// pix_x         in   10  horizontal position
// pix_y         in   10  vertical position
// video_active  in   1   visible-area flag
// hsync_in      in   1   hsync from timing generator
// vsync_in      in   1   vsync from timing generator
// rule          in   8   requested rule number
// wrap          in   1   1=toroidal edges, 0=zero edges
// scroll_en     in   1   1=advance top row one generation per frame
// seed_mode     in   1   0=single centre cell, 1=LFSR pattern
// reseed        in   1   1-clk pulse: request reseed (already synchronised)
// rgb           out  6   {R[1:0],G[1:0],B[1:0]}, registered
// hsync_out     out  1   hsync_in delayed 1 clk
// vsync_out     out  1   vsync_in delayed 1 clk
// BEHAVIOUR
// - Geometry: PAD=(H_ACTIVE-GRID_W*CELL)/2; x=pix_x-PAD; in_grid = video_active & pix_x>=PAD & x<GRID_W*CELL; cell i=x>>LOG_CELL.
// - State: row[GRID_W] (displayed), top[GRID_W] (frame's first row), rule_q, wrap_q, reseed_pend, lfsr[16].
// - gen(v)[i] = rule_q[{L,C,R}], L=v[i-1], C=v[i], R=v[i+1]; out-of-range neighbour = v[wrap index] if wrap_q else 0.
// - Row step (RS): pix_x==H_ACTIVE & pix_y<V_ACTIVE-1 & pix_y[LOG_CELL-1:0]==all-ones -> row<=gen(row).
// - Frame boundary (FB): pix_x==H_ACTIVE & pix_y==V_ACTIVE-1. Priority at FB:
//   reseed_pend|reseed -> top<=seed, row<=seed, clear pend (no scroll this frame);
//   else scroll_en -> top<=gen(top), row<=gen(top); else row<=top.
//   rule_q<=rule, wrap_q<=wrap sampled at FB; the gen() used at this FB uses OLD rule_q/wrap_q.
// - rule/wrap/scroll_en/seed_mode changes mid-frame have no visible effect until next FB.
// - reseed outside FB sets reseed_pend; multiple pulses collapse to one.
// - seed: mode 0 -> only cell GRID_W/2 set; mode 1 -> seed[i]=lfsr[i%16], lfsr value at FB clk.
// - lfsr: Galois, taps 16'hB400, shifts every clk: lfsr<=(lfsr>>1)^(lfsr[0]?16'hB400:0).
// - Output (latency 1 clk from pix_*): rgb<=!in_grid ? 0 : row[i] ? FG_COLOR : BG_COLOR; syncs delayed same 1 clk.
// - Reset (any time, incl. mid-frame): rgb=0, hsync_out=0, vsync_out=0, rule_q=RULE_DEFAULT, wrap_q=0,
//   lfsr=LFSR_INIT, reseed_pend=0, top=row=seed per current seed_mode (with lfsr=LFSR_INIT).
//   After reset, display resumes at current pix_y using the seed row; normal RS/FB apply thereafter.
// TESTING
// 1 GRID_W=100,LOG_CELL=2,rule=30,mode0,wrap0: line0 rgb=FG only pix_x 320..323 (+1clk); line4 cells 49..51 lit.
// 2 GRID_W=8,rule=170(shift left),wrap=1,mode0: line 4k shows only cell (4-k)%8; wrap=0: rows k>=5 all BG.
// 3 rule 30->90 changed at pix_y=100: rest of frame matches rule 30 model; next frame matches rule 90 from line0.
// 4 GRID_W=8,rule=170,wrap=1,scroll_en=1: frame n line0 shows only cell (4-n)%8; scroll_en=0 freezes it.
// 5 seed_mode=1, reseed pulse at pix_y=200 (+second pulse y=300): single reseed at FB; next line0 = lfsr%16 model, no scroll.
// 6 rst_n low 1 clk at pix_y=250: next clk rgb/syncs=0, rule_q=30; next frame line0 = seed; syncs track hsync_in/vsync_in +1clk.

Source files
------------

// File: rtl/ca_vga_renderer.sv
// Elementary 1-D cellular-automaton renderer on top of 640x480 VGA timing.
// Each group of CELL lines shows one generation; the frame's first row can scroll per frame.
module ca_vga_renderer #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          GRID_W       = 100,
  parameter int          LOG_CELL     = 2,
  parameter logic [7:0]  RULE_DEFAULT = 8'd30,
  parameter logic [5:0]  FG_COLOR     = 6'b101100,
  parameter logic [5:0]  BG_COLOR     = 6'b000000,
  parameter logic [15:0] LFSR_INIT    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] rule,
  input  logic       wrap,
  input  logic       scroll_en,
  input  logic       seed_mode,
  input  logic       reseed,
  output logic [5:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int          CELL      = 1 << LOG_CELL;
  localparam int          GRID_PX   = GRID_W * CELL;
  localparam int          PAD       = (H_ACTIVE - GRID_PX) / 2;
  localparam int          IDX_W     = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam logic [9:0]  PAD_X     = 10'(PAD);
  localparam logic [9:0]  GRID_PX_X = 10'(GRID_PX);
  localparam logic [9:0]  H_END     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One generation: bit {L,C,R} of the rule selects each new cell.
  function automatic logic [GRID_W-1:0] gen_row(input logic [GRID_W-1:0] v,
                                                input logic [7:0] r, input logic w);
    logic [GRID_W-1:0] l_vec;
    logic [GRID_W-1:0] r_vec;
    logic [GRID_W-1:0] g;
    l_vec = {v[GRID_W-2:0], w & v[GRID_W-1]};
    r_vec = {w & v[0], v[GRID_W-1:1]};
    g = '0;
    for (int i = 0; i < GRID_W; i++) begin
      g[i] = r[{l_vec[i], v[i], r_vec[i]}];
    end
    return g;
  endfunction

  function automatic logic [GRID_W-1:0] seed_row(input logic mode, input logic [15:0] l);
    logic [GRID_W-1:0] s;
    s = '0;
    for (int i = 0; i < GRID_W; i++) begin
      s[i] = mode ? l[i % 16] : (i == GRID_W / 2);
    end
    return s;
  endfunction

  logic [GRID_W-1:0] row_q, row_d, top_q, top_d;
  logic [7:0]        rule_q, rule_d;
  logic              wrap_q, wrap_d;
  logic              pend_q, pend_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [5:0]        rgb_q, rgb_d;
  logic              hsync_q, vsync_q;

  logic [9:0]        x_s;
  logic              in_grid_s;
  logic [IDX_W-1:0]  idx_s;
  logic              rs_s, fb_s;
  logic [GRID_W-1:0] gen_row_s, gen_top_s, seed_s, rst_seed_s;

  assign x_s        = pix_x - PAD_X;
  assign in_grid_s  = video_active && (pix_x >= PAD_X) && (x_s < GRID_PX_X);
  assign idx_s      = IDX_W'(x_s >> LOG_CELL);
  assign rs_s       = (pix_x == H_END) && (pix_y < V_LAST)
                      && (pix_y[LOG_CELL-1:0] == {LOG_CELL{1'b1}});
  assign fb_s       = (pix_x == H_END) && (pix_y == V_LAST);
  assign gen_row_s  = gen_row(row_q, rule_q, wrap_q);
  assign gen_top_s  = gen_row(top_q, rule_q, wrap_q);
  assign seed_s     = seed_row(seed_mode, lfsr_q);
  assign rst_seed_s = seed_row(seed_mode, LFSR_INIT);

  // Next-state: row stepping, frame-boundary reload/scroll/reseed, LFSR and pixel colour.
  always_comb begin
    row_d  = row_q;
    top_d  = top_q;
    rule_d = rule_q;
    wrap_d = wrap_q;
    pend_d = pend_q;
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    if (fb_s) begin
      // gen() here still runs on the outgoing frame's rule/wrap.
      rule_d = rule;
      wrap_d = wrap;
      if (pend_q || reseed) begin
        top_d  = seed_s;
        row_d  = seed_s;
        pend_d = 1'b0;
      end else if (scroll_en) begin
        top_d = gen_top_s;
        row_d = gen_top_s;
      end else begin
        row_d = top_q;
      end
    end else begin
      if (rs_s) begin
        row_d = gen_row_s;
      end else begin
        row_d = row_q;
      end
      if (reseed) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end
    if (!in_grid_s) begin
      rgb_d = 6'b000000;
    end else if (row_q[idx_s]) begin
      rgb_d = FG_COLOR;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q   <= rst_seed_s;
      top_q   <= rst_seed_s;
      rule_q  <= RULE_DEFAULT;
      wrap_q  <= 1'b0;
      pend_q  <= 1'b0;
      lfsr_q  <= LFSR_INIT;
      rgb_q   <= 6'b000000;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      row_q   <= row_d;
      top_q   <= top_d;
      rule_q  <= rule_d;
      wrap_q  <= wrap_d;
      pend_q  <= pend_d;
      lfsr_q  <= lfsr_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule

// File: tb/tb_ca_vga_renderer.sv
// Directed bench for ca_vga_renderer: compressed lines (scanned cells plus the end-of-line
// pixel) with hand-computed rows and a small cycle model for longer sequences.
module tb_ca_vga_renderer;

  localparam int         W   = 100;
  localparam int         PAD = 120;
  localparam logic [5:0] FG  = 6'b101100;
  localparam logic [5:0] BG  = 6'b000000;

  logic       clk;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       video_active, hsync_in, vsync_in;
  logic [7:0] rule;
  logic       wrap, scroll_en, seed_mode, reseed;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_row, m_top, snap;
  logic [7:0]   m_rule;
  logic         m_wrap, m_pend;
  logic [15:0]  m_lfsr;

  ca_vga_renderer #(
    .H_ACTIVE(640), .V_ACTIVE(480), .GRID_W(W), .LOG_CELL(2), .RULE_DEFAULT(8'd30),
    .FG_COLOR(FG), .BG_COLOR(BG), .LFSR_INIT(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .rule(rule), .wrap(wrap),
    .scroll_en(scroll_en), .seed_mode(seed_mode), .reseed(reseed),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] onehot(input int k);
    logic [W-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] ref_gen(input logic [W-1:0] v, input logic [7:0] r,
                                           input logic w);
    logic [W-1:0] g;
    logic         lb, rb;
    logic [2:0]   nb;
    g = '0;
    for (int i = 0; i < W; i++) begin
      lb = v[(i + W - 1) % W];
      rb = v[(i + 1) % W];
      if (!w && i == 0) lb = 1'b0;
      if (!w && i == W - 1) rb = 1'b0;
      nb = {lb, v[i], rb};
      g[i] = r[nb];
    end
    return g;
  endfunction

  function automatic logic [W-1:0] ref_seed(input logic mode, input logic [15:0] l);
    logic [W-1:0] s;
    s = '0;
    if (mode) begin
      for (int i = 0; i < W; i++) s[i] = l[i % 16];
    end else begin
      s[W/2] = 1'b1;
    end
    return s;
  endfunction

  // Advance the model by the edge about to happen, then move to 1 ns past that edge.
  task automatic tick();
    if (!rst_n) begin
      m_lfsr = 16'hACE1;
      m_rule = 8'd30;
      m_wrap = 1'b0;
      m_pend = 1'b0;
      m_row  = ref_seed(seed_mode, 16'hACE1);
      m_top  = m_row;
    end else begin
      if (pix_x == 10'd640 && pix_y == 10'd479) begin
        if (m_pend || reseed) begin
          m_top  = ref_seed(seed_mode, m_lfsr);
          m_row  = m_top;
          m_pend = 1'b0;
        end else if (scroll_en) begin
          m_top = ref_gen(m_top, m_rule, m_wrap);
          m_row = m_top;
        end else begin
          m_row = m_top;
        end
        m_rule = rule;
        m_wrap = wrap;
      end else begin
        if (pix_x == 10'd640 && pix_y < 10'd479 && pix_y[1:0] == 2'b11)
          m_row = ref_gen(m_row, m_rule, m_wrap);
        if (reseed) m_pend = 1'b1;
      end
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix_chk(input string tag, input int x, input logic va, input logic [5:0] exp);
    pix_x = 10'(x);
    video_active = va;
    tick();
    check(tag, rgb, exp);
  endtask

  // One line: optionally sample every cell, then the end-of-line pixel.
  task automatic line(input int y, input bit scan, input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    int           bad;
    pix_y = 10'(y);
    if (scan) begin
      obs = '0;
      bad = 0;
      for (int c = 0; c < W; c++) begin
        pix_x = 10'(PAD + 4 * c + (c % 4));
        video_active = 1'b1;
        tick();
        obs[c] = (rgb == FG);
        if (rgb != FG && rgb != BG) bad++;
      end
      check(tag, obs, exp);
      check({tag, "_colour"}, bad, 0);
    end
    pix_x = 10'd640;
    video_active = 1'b0;
    tick();
  endtask

  task automatic run_lines(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) line(y, 1'b0, "", '0);
  endtask

  initial begin
    rst_n = 1'b0; pix_x = 10'd700; pix_y = 10'd0; video_active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; rule = 8'd30; wrap = 1'b0;
    scroll_en = 1'b0; seed_mode = 1'b0; reseed = 1'b0;
    tick();
    tick();
    check("rst_rgb", rgb, 6'b000000);
    check("rst_hsync", hsync_out, 1'b0);
    check("rst_vsync", vsync_out, 1'b0);
    rst_n = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b0; tick();
    check("sync_h1", hsync_out, 1'b1);
    check("sync_v0", vsync_out, 1'b0);
    hsync_in = 1'b0; vsync_in = 1'b1; tick();
    check("sync_h0", hsync_out, 1'b0);
    check("sync_v1", vsync_out, 1'b1);
    vsync_in = 1'b0;

    // Rule 30 from a single centre cell.
    pix_y = 10'd0;
    pix_chk("t1_x319", 319, 1'b1, BG);
    pix_chk("t1_x320", 320, 1'b1, FG);
    pix_chk("t1_x323", 323, 1'b1, FG);
    pix_chk("t1_x324", 324, 1'b1, BG);
    pix_chk("t1_blank", 320, 1'b0, 6'b000000);
    line(0, 1'b1, "t1_row0", onehot(50));
    run_lines(1, 3);
    line(4, 1'b1, "t1_row4", onehot(49) | onehot(50) | onehot(51));
    run_lines(5, 7);
    line(8, 1'b1, "t1_row8", onehot(48) | onehot(49) | onehot(52));
    run_lines(9, 199);
    line(200, 1'b1, "t1_row200", m_row);
    run_lines(201, 475);
    line(476, 1'b1, "t1_row476", m_row);
    run_lines(477, 479);

    // Rule change mid-frame only takes effect at the next frame.
    run_lines(0, 99);
    rule = 8'd90;
    run_lines(100, 103);
    line(104, 1'b1, "t3_old_rule", m_row);
    run_lines(105, 299);
    line(300, 1'b1, "t3_old_rule300", m_row);
    run_lines(301, 479);
    line(0, 1'b1, "t3_new_row0", onehot(50));
    run_lines(1, 3);
    line(4, 1'b1, "t3_r90_row4", onehot(49) | onehot(51));
    run_lines(5, 7);
    line(8, 1'b1, "t3_r90_row8", onehot(48) | onehot(52));
    rule = 8'd170;
    wrap = 1'b1;
    run_lines(9, 479);

    // Rule 170 shifts the cell one place per generation; wrap lets it reappear at 99.
    for (int y = 0; y < 480; y++) begin
      if (y == 100) wrap = 1'b0;
      if (y % 4 == 0 && ((y / 4) inside {0, 1, 50, 51, 60, 119}))
        line(y, 1'b1, "t2_wrap", onehot((150 - y / 4) % 100));
      else
        line(y, 1'b0, "", '0);
    end
    for (int y = 0; y < 480; y++) begin
      if (y == 10) begin
        wrap = 1'b1;
        scroll_en = 1'b1;
      end
      if (y % 4 == 0 && ((y / 4) inside {0, 50, 51, 60}))
        line(y, 1'b1, "t2_nowrap", (y / 4 <= 50) ? onehot(50 - y / 4) : '0);
      else
        line(y, 1'b0, "", '0);
    end

    // Per-frame scrolling, then freeze.
    for (int n = 1; n <= 52; n++) begin
      if (n inside {1, 2, 50, 51, 52})
        line(0, 1'b1, "t4_scroll", onehot((n == 52) ? 99 : (150 - n) % 100));
      else
        line(0, 1'b0, "", '0);
      if (n == 51) scroll_en = 1'b0;
      run_lines(1, 479);
    end

    // Two reseed pulses collapse to one reseed at the frame boundary, overriding scroll.
    run_lines(0, 9);
    seed_mode = 1'b1;
    scroll_en = 1'b1;
    run_lines(10, 199);
    reseed = 1'b1;
    line(200, 1'b0, "", '0);
    reseed = 1'b0;
    run_lines(201, 299);
    reseed = 1'b1;
    line(300, 1'b0, "", '0);
    reseed = 1'b0;
    run_lines(301, 479);
    snap = m_row;
    line(0, 1'b1, "t5_seed", snap);
    run_lines(1, 9);
    scroll_en = 1'b0;
    run_lines(10, 479);
    line(0, 1'b1, "t5_hold", snap);
    run_lines(1, 249);

    // Mid-frame reset.
    pix_y = 10'd250;
    pix_x = 10'(PAD + 200);
    video_active = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rst_n = 1'b0;
    tick();
    check("t6_rgb", rgb, 6'b000000);
    check("t6_hsync", hsync_out, 1'b0);
    check("t6_vsync", vsync_out, 1'b0);
    rst_n = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    pix_x = 10'd640;
    video_active = 1'b0;
    tick();
    check("t6_sync_track_h", hsync_out, 1'b0);
    line(251, 1'b1, "t6_seed_row", ref_seed(1'b1, 16'hACE1));
    line(252, 1'b1, "t6_rule30", m_row);
    run_lines(253, 479);
    line(0, 1'b1, "t6_next_seed", ref_seed(1'b1, 16'hACE1));
    run_lines(1, 3);
    line(4, 1'b1, "t6_next_gen", m_row);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
